// File: rtl/sfq_pkg.sv
// Shared types and helpers for the clocked SFQ coincidence gate model.
package sfq_pkg;

  // Evaluation rule applied to the latched arrivals when the SFQ clock pulses.
  typedef enum logic [1:0] {
    SFQ_AND    = 2'd0,
    SFQ_OR     = 2'd1,
    SFQ_THRESH = 2'd2
  } sfq_mode_e;

  localparam int SFQ_MAX_IN = 16;

  // Number of set bits in a vector of up to 16 channels (narrower inputs are zero-extended).
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < SFQ_MAX_IN; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/sfq_tgl_edge.sv
// Toggle-to-event converter: an SFQ pulse is any change of the sampled level.
module sfq_tgl_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic tgl,
  output logic evt
);

  logic prev;

  // Remember last cycle's sample; reset assumes the line idles low.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= tgl;
  end

  assign evt = tgl ^ prev;

endmodule

// File: rtl/sfq_clocked_coincidence_gate.sv
// Cycle-based model of an N-input clocked SFQ coincidence gate (AND/OR/threshold),
// with toggle-encoded I/O, setup-age tracking and sticky violation flags.
module sfq_clocked_coincidence_gate
  import sfq_pkg::*;
#(
  parameter int N_IN      = 2,
  parameter int MODE      = 0,
  parameter int THRESH    = 2,
  parameter int SETUP_CYC = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  in_tgl,
  input  logic             clk_tgl,
  output logic             q_tgl,
  output logic             q_pulse,
  output logic [N_IN-1:0]  arrived,
  output logic             err_double,
  output logic             err_setup,
  output logic [CNT_W-1:0] pulse_cnt
);

  localparam sfq_mode_e MODE_E = sfq_mode_e'(2'(MODE));

  // Parameter sanity, reported at elaboration.
  if (N_IN < 2 || N_IN > SFQ_MAX_IN) begin : g_bad_n_in
    $error("sfq_clocked_coincidence_gate: N_IN=%0d outside 2..16", N_IN);
  end
  if (MODE < 0 || MODE > 2) begin : g_bad_mode
    $error("sfq_clocked_coincidence_gate: MODE=%0d is not 0, 1 or 2", MODE);
  end
  if (THRESH < 1 || THRESH > N_IN) begin : g_bad_thresh
    $error("sfq_clocked_coincidence_gate: THRESH=%0d outside 1..N_IN", THRESH);
  end
  if (SETUP_CYC < 0) begin : g_bad_setup
    $error("sfq_clocked_coincidence_gate: SETUP_CYC=%0d is negative", SETUP_CYC);
  end

  // Pulse detection on every data line and on the SFQ clock line.
  logic [N_IN-1:0] data_evt;
  logic            eval_evt;

  for (genvar i = 0; i < N_IN; i++) begin : g_data_edge
    sfq_tgl_edge u_edge (
      .clk   (clk),
      .rst_n (rst_n),
      .tgl   (in_tgl[i]),
      .evt   (data_evt[i])
    );
  end

  sfq_tgl_edge u_clk_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .tgl   (clk_tgl),
    .evt   (eval_evt)
  );

  // Arrivals seen by an eval: already latched plus those landing in the same cycle.
  logic [N_IN-1:0] counted;
  logic [4:0]      count;
  logic            fire;
  logic            setup_viol;

  // Gate decision for the current cycle's arrival set.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and a latch can never be inferred.
  always_comb begin
    fire    = 1'b0;
    counted = arrived | data_evt;
    count   = popcount16(16'(counted));
    case (MODE_E)
      SFQ_AND:    fire = (count == 5'(N_IN));
      SFQ_OR:     fire = (count != 5'd0);
      SFQ_THRESH: fire = (count >= 5'(THRESH));
      default:    fire = 1'b0;
    endcase
  end

  // Per-channel age tracking exists only when the setup check is enabled.
  if (SETUP_CYC > 0) begin : g_setup
    localparam int AGE_W = (SETUP_CYC > 1) ? $clog2(SETUP_CYC + 1) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(SETUP_CYC);

    logic [N_IN-1:0] young;

    for (genvar i = 0; i < N_IN; i++) begin : g_age
      logic [AGE_W-1:0] age;

      // Cycles since this channel's arrival, saturating at the setup requirement.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          age <= '0;
        end else if (eval_evt || (data_evt[i] && !arrived[i])) begin
          age <= '0;
        end else if (arrived[i] && age != AGE_MAX) begin
          age <= age + AGE_W'(1);
        end
      end

      // A same-cycle arrival counts as age 0, hence always too young.
      assign young[i] = (data_evt[i] & ~arrived[i]) |
                        (arrived[i] & (age < AGE_MAX));
    end

    assign setup_viol = |young;
  end else begin : g_no_setup
    assign setup_viol = 1'b0;
  end

  // Arrival latches, output toggle/strobe, pulse counter and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arrived    <= '0;
      q_tgl      <= 1'b0;
      q_pulse    <= 1'b0;
      err_double <= 1'b0;
      err_setup  <= 1'b0;
      pulse_cnt  <= '0;
    end else begin
      q_pulse <= 1'b0;

      if (|(data_evt & arrived)) err_double <= 1'b1;

      if (eval_evt) begin
        // Eval consumes latched and same-cycle arrivals alike; the window closes.
        arrived <= '0;
        if (setup_viol) err_setup <= 1'b1;
        if (fire) begin
          q_tgl     <= ~q_tgl;
          q_pulse   <= 1'b1;
          pulse_cnt <= pulse_cnt + CNT_W'(1);
        end
      end else begin
        arrived <= arrived | data_evt;
      end
    end
  end

endmodule

// File: tb/tb_sfq_clocked_coincidence_gate.sv
// Directed testbench for sfq_clocked_coincidence_gate: four instances cover
// AND (setup 1), AND (setup 2), threshold-3-of-4 and OR (setup check off).
module tb_sfq_clocked_coincidence_gate;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // Instance A: N_IN=2, AND, SETUP_CYC=1
  logic [1:0] a_in = '0;
  logic       a_clk = 1'b0;
  logic       a_q, a_qp, a_ed, a_es;
  logic [1:0] a_arr;
  logic [7:0] a_cnt;

  // Instance S: N_IN=2, AND, SETUP_CYC=2
  logic [1:0] s_in = '0;
  logic       s_clk = 1'b0;
  logic       s_q, s_qp, s_ed, s_es;
  logic [1:0] s_arr;
  logic [7:0] s_cnt;

  // Instance T: N_IN=4, THRESH mode, THRESH=3
  logic [3:0] t_in = '0;
  logic       t_clk = 1'b0;
  logic       t_q, t_qp, t_ed, t_es;
  logic [3:0] t_arr;
  logic [7:0] t_cnt;

  // Instance O: N_IN=2, OR, setup check disabled
  logic [1:0] o_in = '0;
  logic       o_clk = 1'b0;
  logic       o_q, o_qp, o_ed, o_es;
  logic [1:0] o_arr;
  logic [7:0] o_cnt;

  sfq_clocked_coincidence_gate #(.N_IN(2), .MODE(0), .THRESH(2), .SETUP_CYC(1), .CNT_W(8)) u_and (
    .clk(clk), .rst_n(rst_n), .in_tgl(a_in), .clk_tgl(a_clk), .q_tgl(a_q), .q_pulse(a_qp),
    .arrived(a_arr), .err_double(a_ed), .err_setup(a_es), .pulse_cnt(a_cnt));

  sfq_clocked_coincidence_gate #(.N_IN(2), .MODE(0), .THRESH(2), .SETUP_CYC(2), .CNT_W(8)) u_setup (
    .clk(clk), .rst_n(rst_n), .in_tgl(s_in), .clk_tgl(s_clk), .q_tgl(s_q), .q_pulse(s_qp),
    .arrived(s_arr), .err_double(s_ed), .err_setup(s_es), .pulse_cnt(s_cnt));

  sfq_clocked_coincidence_gate #(.N_IN(4), .MODE(2), .THRESH(3), .SETUP_CYC(1), .CNT_W(8)) u_thr (
    .clk(clk), .rst_n(rst_n), .in_tgl(t_in), .clk_tgl(t_clk), .q_tgl(t_q), .q_pulse(t_qp),
    .arrived(t_arr), .err_double(t_ed), .err_setup(t_es), .pulse_cnt(t_cnt));

  sfq_clocked_coincidence_gate #(.N_IN(2), .MODE(1), .THRESH(1), .SETUP_CYC(0), .CNT_W(8)) u_or (
    .clk(clk), .rst_n(rst_n), .in_tgl(o_in), .clk_tgl(o_clk), .q_tgl(o_q), .q_pulse(o_qp),
    .arrived(o_arr), .err_double(o_ed), .err_setup(o_es), .pulse_cnt(o_cnt));

  // One sampling edge; outputs are observed 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset with every toggle line returned low before release.
  task automatic do_reset();
    rst_n = 1'b0;
    a_in = '0; a_clk = 1'b0;
    s_in = '0; s_clk = 1'b0;
    t_in = '0; t_clk = 1'b0;
    o_in = '0; o_clk = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    checks++; if ({a_q, a_qp, a_arr, a_ed, a_es, a_cnt} !== 14'd0) begin failures++; $display("FAIL reset_a got=%h exp=0", {a_q, a_qp, a_arr, a_ed, a_es, a_cnt}); end
    checks++; if ({s_q, s_qp, s_arr, s_ed, s_es, s_cnt} !== 14'd0) begin failures++; $display("FAIL reset_s got=%h exp=0", {s_q, s_qp, s_arr, s_ed, s_es, s_cnt}); end
    checks++; if ({t_q, t_qp, t_arr, t_ed, t_es, t_cnt} !== 16'd0) begin failures++; $display("FAIL reset_t got=%h exp=0", {t_q, t_qp, t_arr, t_ed, t_es, t_cnt}); end
    checks++; if ({o_q, o_qp, o_arr, o_ed, o_es, o_cnt} !== 14'd0) begin failures++; $display("FAIL reset_o got=%h exp=0", {o_q, o_qp, o_arr, o_ed, o_es, o_cnt}); end
  endtask

  // a, then b, then eval a few cycles later: AND fires.
  task automatic test_and_fire();
    do_reset();
    a_in[0] = 1'b1; step();
    checks++; if (a_arr !== 2'b01) begin failures++; $display("FAIL and_arr_a got=%b exp=01", a_arr); end
    step();
    a_in[1] = 1'b1; step();
    checks++; if (a_arr !== 2'b11) begin failures++; $display("FAIL and_arr_ab got=%b exp=11", a_arr); end
    step(); step();
    a_clk = 1'b1; step();
    checks++; if (a_q !== 1'b1) begin failures++; $display("FAIL and_q got=%b exp=1", a_q); end
    checks++; if (a_qp !== 1'b1) begin failures++; $display("FAIL and_qp got=%b exp=1", a_qp); end
    checks++; if (a_cnt !== 8'd1) begin failures++; $display("FAIL and_cnt got=%0d exp=1", a_cnt); end
    checks++; if (a_arr !== 2'b00) begin failures++; $display("FAIL and_arr_clr got=%b exp=00", a_arr); end
    checks++; if (a_es !== 1'b0) begin failures++; $display("FAIL and_es got=%b exp=0", a_es); end
    step();
    checks++; if (a_qp !== 1'b0) begin failures++; $display("FAIL and_qp_drop got=%b exp=0", a_qp); end
    checks++; if (a_q !== 1'b1) begin failures++; $display("FAIL and_q_hold got=%b exp=1", a_q); end
  endtask

  // Only a arrives: no fire, window still cleared.
  task automatic test_and_nofire();
    do_reset();
    a_in[0] = 1'b1; step();
    checks++; if (a_arr !== 2'b01) begin failures++; $display("FAIL nofire_arr got=%b exp=01", a_arr); end
    step();
    a_clk = 1'b1; step();
    checks++; if ({a_q, a_qp} !== 2'b00) begin failures++; $display("FAIL nofire_q got=%b exp=00", {a_q, a_qp}); end
    checks++; if (a_arr !== 2'b00) begin failures++; $display("FAIL nofire_arr_clr got=%b exp=00", a_arr); end
    checks++; if (a_cnt !== 8'd0) begin failures++; $display("FAIL nofire_cnt got=%0d exp=0", a_cnt); end
  endtask

  // Second pulse on a set channel is flagged, stays flagged, gate still fires once.
  task automatic test_double();
    do_reset();
    a_in[0] = 1'b1; step();
    a_in[0] = 1'b0; step();
    checks++; if (a_ed !== 1'b1) begin failures++; $display("FAIL dbl_err got=%b exp=1", a_ed); end
    checks++; if (a_arr !== 2'b01) begin failures++; $display("FAIL dbl_arr got=%b exp=01", a_arr); end
    a_in[1] = 1'b1; step();
    step(); step();
    a_clk = 1'b1; step();
    checks++; if ({a_q, a_qp} !== 2'b11) begin failures++; $display("FAIL dbl_fire got=%b exp=11", {a_q, a_qp}); end
    checks++; if (a_cnt !== 8'd1) begin failures++; $display("FAIL dbl_cnt got=%0d exp=1", a_cnt); end
    step();
    checks++; if (a_ed !== 1'b1) begin failures++; $display("FAIL dbl_sticky got=%b exp=1", a_ed); end
    checks++; if (a_es !== 1'b0) begin failures++; $display("FAIL dbl_es got=%b exp=0", a_es); end
  endtask

  // SETUP_CYC=2: aged arrivals are clean, a same-cycle arrival raises err_setup.
  task automatic test_setup();
    do_reset();
    s_in = 2'b11; step();
    step(); step();
    s_clk = 1'b1; step();
    checks++; if ({s_q, s_qp} !== 2'b11) begin failures++; $display("FAIL setup_ok_fire got=%b exp=11", {s_q, s_qp}); end
    checks++; if (s_es !== 1'b0) begin failures++; $display("FAIL setup_ok_es got=%b exp=0", s_es); end
    // Arrival in the cycle right after an eval opens a new window.
    s_in[0] = 1'b0; step();
    checks++; if (s_arr !== 2'b01) begin failures++; $display("FAIL setup_newwin got=%b exp=01", s_arr); end
    step(); step(); step();
    s_in[1] = 1'b0; s_clk = 1'b0; step();
    checks++; if ({s_q, s_qp} !== 2'b01) begin failures++; $display("FAIL setup_late_fire got=%b exp=01", {s_q, s_qp}); end
    checks++; if (s_es !== 1'b1) begin failures++; $display("FAIL setup_late_es got=%b exp=1", s_es); end
    checks++; if (s_cnt !== 8'd2) begin failures++; $display("FAIL setup_cnt got=%0d exp=2", s_cnt); end
    checks++; if (s_arr !== 2'b00) begin failures++; $display("FAIL setup_arr got=%b exp=00", s_arr); end
    step();
    checks++; if (s_es !== 1'b1) begin failures++; $display("FAIL setup_sticky got=%b exp=1", s_es); end
  endtask

  // Threshold 3 of 4: three arrivals fire, two do not.
  task automatic test_thresh();
    do_reset();
    t_in[0] = 1'b1; step();
    t_in[1] = 1'b1; step();
    t_in[2] = 1'b1; step();
    checks++; if (t_arr !== 4'b0111) begin failures++; $display("FAIL thr_arr3 got=%b exp=0111", t_arr); end
    step(); step();
    t_clk = 1'b1; step();
    checks++; if ({t_q, t_qp} !== 2'b11) begin failures++; $display("FAIL thr_fire got=%b exp=11", {t_q, t_qp}); end
    checks++; if (t_arr !== 4'b0000) begin failures++; $display("FAIL thr_clr got=%b exp=0000", t_arr); end
    t_in[1] = 1'b0; step();
    t_in[3] = 1'b1; step();
    checks++; if (t_arr !== 4'b1010) begin failures++; $display("FAIL thr_arr2 got=%b exp=1010", t_arr); end
    step();
    t_clk = 1'b0; step();
    checks++; if ({t_q, t_qp} !== 2'b10) begin failures++; $display("FAIL thr_nofire got=%b exp=10", {t_q, t_qp}); end
    checks++; if (t_cnt !== 8'd1) begin failures++; $display("FAIL thr_cnt got=%0d exp=1", t_cnt); end
    checks++; if (t_arr !== 4'b0000) begin failures++; $display("FAIL thr_clr2 got=%b exp=0000", t_arr); end
  endtask

  // OR with setup check off: same-cycle arrival fires without err_setup.
  task automatic test_or();
    do_reset();
    o_in[1] = 1'b1; o_clk = 1'b1; step();
    checks++; if ({o_q, o_qp} !== 2'b11) begin failures++; $display("FAIL or_fire got=%b exp=11", {o_q, o_qp}); end
    checks++; if (o_es !== 1'b0) begin failures++; $display("FAIL or_es got=%b exp=0", o_es); end
    checks++; if (o_arr !== 2'b00) begin failures++; $display("FAIL or_consumed got=%b exp=00", o_arr); end
    o_in[0] = 1'b1; step();
    checks++; if (o_arr !== 2'b01) begin failures++; $display("FAIL or_newwin got=%b exp=01", o_arr); end
    o_clk = 1'b0; step();
    checks++; if ({o_q, o_qp, o_cnt} !== {2'b01, 8'd2}) begin failures++; $display("FAIL or_fire2 got=%h exp=%h", {o_q, o_qp, o_cnt}, {2'b01, 8'd2}); end
    o_clk = 1'b1; step();
    checks++; if ({o_q, o_qp, o_cnt} !== {2'b00, 8'd2}) begin failures++; $display("FAIL or_empty got=%h exp=%h", {o_q, o_qp, o_cnt}, {2'b00, 8'd2}); end
  endtask

  // Reset mid-window discards arrivals; then 256 fires wrap the 8-bit counter.
  task automatic test_reset_mid();
    do_reset();
    a_in = 2'b11; step();
    checks++; if (a_arr !== 2'b11) begin failures++; $display("FAIL mid_arr got=%b exp=11", a_arr); end
    rst_n = 1'b0; #1;
    checks++; if ({a_q, a_qp, a_arr, a_ed, a_es, a_cnt} !== 14'd0) begin failures++; $display("FAIL mid_async got=%h exp=0", {a_q, a_qp, a_arr, a_ed, a_es, a_cnt}); end
    a_in = 2'b00; step();
    rst_n = 1'b1; step();
    a_clk = 1'b1; step();
    checks++; if ({a_q, a_qp, a_arr, a_cnt} !== 12'd0) begin failures++; $display("FAIL mid_nofire got=%h exp=0", {a_q, a_qp, a_arr, a_cnt}); end
    for (int i = 0; i < 256; i++) begin
      a_in  = ~a_in;
      a_clk = ~a_clk;
      step();
      if (i == 254) begin
        checks++; if ({a_q, a_cnt} !== {1'b1, 8'd255}) begin failures++; $display("FAIL wrap_255 got=%h exp=%h", {a_q, a_cnt}, {1'b1, 8'd255}); end
      end
    end
    checks++; if (a_cnt !== 8'd0) begin failures++; $display("FAIL wrap_cnt got=%0d exp=0", a_cnt); end
    checks++; if ({a_q, a_qp} !== 2'b01) begin failures++; $display("FAIL wrap_q got=%b exp=01", {a_q, a_qp}); end
  endtask

  initial begin
    test_reset();
    test_and_fire();
    test_and_nofire();
    test_double();
    test_setup();
    test_thresh();
    test_or();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
